// File: rtl/data_mem_controller.sv
// data_mem_controller: MEM-stage request/ready data-memory interface with big-endian byte lanes
module data_mem_controller #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [31:0] MEM_Address,
  input  logic [31:0] MEM_WriteData,
  input  logic [1:0]  MEM_Size,
  input  logic        MEM_SignExtend,
  input  logic        MEM_Stall,
  output logic [31:0] MEM_ReadData,
  output logic        MEM_Stall_Controller,
  output logic        MEM_AddrError,
  output logic        MEM_BusError,
  output logic [29:0] DataMem_Address,
  output logic [31:0] DataMem_WriteData,
  output logic [3:0]  DataMem_ByteEn,
  output logic        DataMem_Read,
  output logic        DataMem_Write,
  input  logic        DataMem_Ready,
  input  logic [31:0] DataMem_ReadData
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic req, is_byte, is_half, misaligned, start, timeout;
  logic [7:0] cnt;
  logic [29:0] addr_q;
  logic [1:0] off_q, size_q;
  logic sign_q, write_q, bus_err_q;
  logic [31:0] wdata_q, rdata_q, wdata_nx, lane, load_val;
  logic [3:0] be_q, be_nx;
  assign req = MEM_MemRead | MEM_MemWrite;
  assign is_byte = MEM_Size == 2'b10;
  assign is_half = MEM_Size == 2'b01;
  assign misaligned = is_half ? MEM_Address[0] : !is_byte && MEM_Address[1:0] != 2'b00;
  // Gated by reset so every output reads 0 while reset is held, even with a request present.
  assign start = reset && state == IDLE && req && !misaligned;
  assign timeout = state == ACCESS && !DataMem_Ready && cnt == 8'(TIMEOUT - 1);
  assign be_nx = is_byte ? 4'b1000 >> MEM_Address[1:0] : is_half ? (MEM_Address[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign wdata_nx = is_byte ? {4{MEM_WriteData[7:0]}} : is_half ? {2{MEM_WriteData[15:0]}} : MEM_WriteData;
  // Shifting by the byte offset moves the addressed lane to the top of the word.
  assign lane = DataMem_ReadData << {off_q, 3'b000};
  assign load_val = size_q == 2'b10 ? {{24{sign_q & lane[31]}}, lane[31:24]}
                  : size_q == 2'b01 ? {{16{sign_q & lane[31]}}, lane[31:16]} : DataMem_ReadData;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ACCESS : IDLE;
      ACCESS:  state_nx = (DataMem_Ready || timeout) ? DONE : ACCESS;
      DONE:    state_nx = MEM_Stall ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    MEM_Stall_Controller = start || state == ACCESS;
    MEM_AddrError = reset && state == IDLE && req && misaligned;
    DataMem_Read = state == ACCESS && !write_q;
    DataMem_Write = state == ACCESS && write_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      addr_q <= '0;
      off_q <= '0;
      size_q <= '0;
      sign_q <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      be_q <= '0;
      rdata_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout;
      if (start) begin
        cnt <= '0;
        addr_q <= MEM_Address[31:2];
        off_q <= MEM_Address[1:0];
        size_q <= MEM_Size;
        sign_q <= MEM_SignExtend;
        write_q <= MEM_MemWrite;
        wdata_q <= wdata_nx;
        be_q <= be_nx;
      end else if (state == ACCESS) begin
        cnt <= cnt + 8'd1;
        if (DataMem_Ready) rdata_q <= write_q ? '0 : load_val;
        else if (timeout) rdata_q <= '0;
      end
    end
  end
  assign MEM_ReadData = rdata_q;
  assign MEM_BusError = bus_err_q;
  assign DataMem_Address = addr_q;
  assign DataMem_WriteData = wdata_q;
  assign DataMem_ByteEn = be_q;
endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller: directed self-checking bench for data_mem_controller
module tb_data_mem_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0, sign_ext = 1'b0, mem_stall = 1'b0, ready = 1'b0;
  logic [31:0] address = '0, write_data = '0, mem_word = '0;
  logic [1:0] size = '0;
  logic [31:0] read_data, dm_wdata;
  logic [29:0] dm_addr;
  logic [3:0] dm_be;
  logic stall_ctl, addr_err, bus_err, dm_read, dm_write;
  int checks = 0;
  int failures = 0;
  int n_stall, n_strobe;
  logic [31:0] s_addr, s_wdata;
  logic [3:0] s_be;
  logic s_wr;
  data_mem_controller #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .MEM_MemRead(mem_read), .MEM_MemWrite(mem_write), .MEM_Address(address),
    .MEM_WriteData(write_data), .MEM_Size(size), .MEM_SignExtend(sign_ext),
    .MEM_Stall(mem_stall), .MEM_ReadData(read_data), .MEM_Stall_Controller(stall_ctl),
    .MEM_AddrError(addr_err), .MEM_BusError(bus_err), .DataMem_Address(dm_addr),
    .DataMem_WriteData(dm_wdata), .DataMem_ByteEn(dm_be), .DataMem_Read(dm_read),
    .DataMem_Write(dm_write), .DataMem_Ready(ready), .DataMem_ReadData(mem_word)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sx, input logic [31:0] mw);
    mem_read = rd; mem_write = wr; address = a; write_data = wd; size = sz; sign_ext = sx; mem_word = mw;
  endtask
  task automatic idle();
    mem_read = 1'b0; mem_write = 1'b0; mem_stall = 1'b0; ready = 1'b0;
    @(negedge clock);
  endtask
  // Called at a negedge with the request applied; returns #1 into the first cycle without stall.
  // waits < 0 means memory never answers.
  task automatic run(input int waits);
    int acc;
    acc = 0; n_stall = 0; n_strobe = 0; s_wr = 1'b0;
    s_addr = '0; s_wdata = '0; s_be = '0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (dm_read || dm_write) begin
        ready = waits >= 0 && acc == waits;
        acc++; n_strobe++;
        s_addr = {2'b00, dm_addr}; s_wdata = dm_wdata; s_be = dm_be; s_wr = dm_write;
      end else ready = 1'b0;
      if (!stall_ctl) break;
      n_stall++;
      @(negedge clock);
    end
  endtask
  initial begin
    repeat (2) @(negedge clock);
    #1;
    chk("rst_readdata", read_data, 32'h0);
    chk("rst_stall", {31'b0, stall_ctl}, 32'h0);
    chk("rst_strobes", {30'b0, dm_read, dm_write}, 32'h0);
    chk("rst_buserr", {31'b0, bus_err}, 32'h0);
    chk("rst_be_addr", {dm_be, dm_addr[27:0]}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    // LW 0x100, zero-wait
    set_req(1, 0, 32'h100, 0, 2'b00, 0, 32'hDEADBEEF);
    run(0);
    chk("lw_stall", n_stall, 2);
    chk("lw_strobe", n_strobe, 1);
    chk("lw_addr", s_addr, 32'h40);
    chk("lw_be", {28'b0, s_be}, 32'hF);
    chk("lw_dir", {31'b0, s_wr}, 32'h0);
    chk("lw_data", read_data, 32'hDEADBEEF);
    idle();
    // LB / LBU 0x103
    set_req(1, 0, 32'h103, 0, 2'b10, 1, 32'h123456F0);
    run(0);
    chk("lb_be", {28'b0, s_be}, 32'h1);
    chk("lb_data", read_data, 32'hFFFFFFF0);
    idle();
    set_req(1, 0, 32'h103, 0, 2'b10, 0, 32'h123456F0);
    run(0);
    chk("lbu_data", read_data, 32'h000000F0);
    idle();
    // LB 0x100 takes the top lane
    set_req(1, 0, 32'h100, 0, 2'b10, 1, 32'h7F0000FF);
    run(0);
    chk("lb0_be", {28'b0, s_be}, 32'h8);
    chk("lb0_data", read_data, 32'h0000007F);
    idle();
    // LH 0x102 aligned, sign-extended low half
    set_req(1, 0, 32'h102, 0, 2'b01, 1, 32'h12348765);
    #1;
    chk("lh_noerr", {31'b0, addr_err}, 32'h0);
    run(0);
    chk("lh_be", {28'b0, s_be}, 32'h3);
    chk("lh_data", read_data, 32'hFFFF8765);
    idle();
    set_req(1, 0, 32'h100, 0, 2'b01, 0, 32'h87651234);
    run(1);
    chk("lhu_be", {28'b0, s_be}, 32'hC);
    chk("lhu_data", read_data, 32'h00008765);
    chk("lhu_stall", n_stall, 3);
    idle();
    // SH 0x202, three wait cycles
    set_req(0, 1, 32'h202, 32'h0000ABCD, 2'b01, 0, 32'hFFFFFFFF);
    run(3);
    chk("sh_wdata", s_wdata, 32'hABCDABCD);
    chk("sh_be", {28'b0, s_be}, 32'h3);
    chk("sh_strobe", n_strobe, 4);
    chk("sh_stall", n_stall, 5);
    chk("sh_dir", {31'b0, s_wr}, 32'h1);
    chk("sh_rdata", read_data, 32'h0);
    idle();
    // SB 0x301
    set_req(0, 1, 32'h301, 32'hFFFFFF5A, 2'b10, 0, 0);
    run(0);
    chk("sb_wdata", s_wdata, 32'h5A5A5A5A);
    chk("sb_be", {28'b0, s_be}, 32'h4);
    idle();
    // read and write together behave as a store; size 11 is a word
    set_req(1, 1, 32'h400, 32'h11223344, 2'b11, 0, 32'h99999999);
    run(0);
    chk("rw_dir", {31'b0, s_wr}, 32'h1);
    chk("rw_wdata", s_wdata, 32'h11223344);
    chk("rw_be", {28'b0, s_be}, 32'hF);
    chk("rw_rdata", read_data, 32'h0);
    idle();
    // LW 0x101 misaligned
    set_req(1, 0, 32'h101, 0, 2'b00, 0, 0);
    #1;
    chk("mis_err", {31'b0, addr_err}, 32'h1);
    chk("mis_stall", {31'b0, stall_ctl}, 32'h0);
    @(negedge clock);
    #1;
    chk("mis_noread", {30'b0, dm_read, dm_write}, 32'h0);
    chk("mis_idle_err", {31'b0, addr_err}, 32'h1);
    idle();
    // timeout with TIMEOUT=8
    set_req(1, 0, 32'h500, 0, 2'b00, 0, 32'h55555555);
    run(-1);
    chk("to_strobe", n_strobe, 8);
    chk("to_stall", n_stall, 9);
    chk("to_buserr", {31'b0, bus_err}, 32'h1);
    chk("to_rdata", read_data, 32'h0);
    idle();
    #1;
    chk("to_pulse", {31'b0, bus_err}, 32'h0);
    @(negedge clock);
    // hold in DONE for three frozen cycles
    set_req(1, 0, 32'h10, 0, 2'b00, 0, 32'hCAFEF00D);
    run(0);
    mem_stall = 1'b1;
    mem_word = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      chk("hold_data", read_data, 32'hCAFEF00D);
      chk("hold_strobe", {30'b0, dm_read, dm_write}, 32'h0);
      chk("hold_stall", {31'b0, stall_ctl}, 32'h0);
    end
    idle();
    // reset asserted mid-access
    set_req(1, 0, 32'h600, 0, 2'b00, 0, 32'h0BADF00D);
    @(negedge clock);
    #1;
    chk("rstacc_read", {31'b0, dm_read}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rstacc_drop", {31'b0, dm_read}, 32'h0);
    chk("rstacc_stall", {31'b0, stall_ctl}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    run(0);
    chk("rstacc_restart", n_stall, 2);
    chk("rstacc_data", read_data, 32'h0BADF00D);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
